// File: rtl/reg_read_stage.sv
// Register-read stage: 16x32 register file, operand read with forwarding from
// execute, and the registered rr_* bundle that feeds execute.
module reg_read_stage #(
  parameter int NREGS = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        dec_valid,
  input  logic [31:0] dec_pc,
  input  logic [31:0] dec_imm32,
  input  logic [31:0] dec_pc_inc,
  input  logic [5:0]  dec_op,
  input  logic [7:0]  dec_altop,
  input  logic [3:0]  dec_rd,
  input  logic [3:0]  dec_rs,
  input  logic [3:0]  dec_rt,
  input  logic        dec_next_is_cont,
  input  logic        exec_stall,
  input  logic        exec_flush,
  input  logic [3:0]  exec_of_reg,
  input  logic [31:0] exec_of_val,
  input  logic [3:0]  exec_rd,
  input  logic [31:0] exec_rd_val,
  output logic [31:0] rr_pc,
  output logic [31:0] rr_imm32,
  output logic [31:0] rr_pc_inc,
  output logic [31:0] rr_rs_val,
  output logic [31:0] rr_rt_val,
  output logic [5:0]  rr_op,
  output logic [7:0]  rr_altop,
  output logic [3:0]  rr_rd,
  output logic        rr_next_is_cont,
  output logic        rr_stall
);

  logic [31:0] regs [NREGS];
  logic [31:0] rs_sel;
  logic [31:0] rt_sel;

  // Execute-stage forward outranks the same-cycle writeback bypass.
  function automatic logic [31:0] operand(
    input logic [3:0]  idx,
    input logic [31:0] rf_val,
    input logic [3:0]  of_reg,
    input logic [31:0] of_val,
    input logic [3:0]  wb_rd,
    input logic [31:0] wb_val
  );
    logic [31:0] val;
    if (idx == 4'd0)        val = '0;
    else if (idx == of_reg) val = of_val;
    else if (idx == wb_rd)  val = wb_val;
    else                    val = rf_val;
    return val;
  endfunction

  always_comb begin
    rs_sel = operand(dec_rs, regs[dec_rs], exec_of_reg, exec_of_val, exec_rd, exec_rd_val);
    rt_sel = operand(dec_rt, regs[dec_rt], exec_of_reg, exec_of_val, exec_rd, exec_rd_val);
  end

  assign rr_stall = exec_stall;

  // Writeback ignores stall; execute keeps exec_rd stable so rewrites are benign.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (exec_rd != 4'd0) begin
      regs[exec_rd] <= exec_rd_val;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || (!exec_stall && (exec_flush || !dec_valid))) begin
      rr_pc           <= '0;
      rr_imm32        <= '0;
      rr_pc_inc       <= '0;
      rr_rs_val       <= '0;
      rr_rt_val       <= '0;
      rr_op           <= '0;
      rr_altop        <= '0;
      rr_rd           <= '0;
      rr_next_is_cont <= 1'b0;
    end else if (!exec_stall) begin
      rr_pc           <= dec_pc;
      rr_imm32        <= dec_imm32;
      rr_pc_inc       <= dec_pc_inc;
      rr_rs_val       <= rs_sel;
      rr_rt_val       <= rt_sel;
      rr_op           <= dec_op;
      rr_altop        <= dec_altop;
      rr_rd           <= dec_rd;
      rr_next_is_cont <= dec_next_is_cont;
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: a directed vector table, hand sequences for reset
// and stall corners, then random traffic against an abstract model.
module tb_reg_read_stage;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        dec_valid, dec_next_is_cont;
  logic [31:0] dec_pc, dec_imm32, dec_pc_inc;
  logic [5:0]  dec_op;
  logic [7:0]  dec_altop;
  logic [3:0]  dec_rd, dec_rs, dec_rt;
  logic        exec_stall, exec_flush;
  logic [3:0]  exec_of_reg, exec_rd;
  logic [31:0] exec_of_val, exec_rd_val;
  logic [31:0] rr_pc, rr_imm32, rr_pc_inc, rr_rs_val, rr_rt_val;
  logic [5:0]  rr_op;
  logic [7:0]  rr_altop;
  logic [3:0]  rr_rd;
  logic        rr_next_is_cont, rr_stall;

  int checks = 0;
  int errors = 0;

  reg_read_stage #(.NREGS(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_imm32(dec_imm32),
    .dec_pc_inc(dec_pc_inc), .dec_op(dec_op), .dec_altop(dec_altop),
    .dec_rd(dec_rd), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_next_is_cont(dec_next_is_cont),
    .exec_stall(exec_stall), .exec_flush(exec_flush),
    .exec_of_reg(exec_of_reg), .exec_of_val(exec_of_val),
    .exec_rd(exec_rd), .exec_rd_val(exec_rd_val),
    .rr_pc(rr_pc), .rr_imm32(rr_imm32), .rr_pc_inc(rr_pc_inc),
    .rr_rs_val(rr_rs_val), .rr_rt_val(rr_rt_val), .rr_op(rr_op),
    .rr_altop(rr_altop), .rr_rd(rr_rd), .rr_next_is_cont(rr_next_is_cont),
    .rr_stall(rr_stall)
  );

  always #5 i_clk = ~i_clk;

  // Abstract model: architectural register contents plus the expected bundle.
  logic [31:0] m_regs [16];
  logic [31:0] e_pc, e_imm, e_pcinc, e_rs, e_rt;
  logic [5:0]  e_op;
  logic [7:0]  e_altop;
  logic [3:0]  e_rd;
  logic        e_nic;

  typedef struct {
    logic        stall, flush, valid;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [3:0]  rd, rs, rt, of_reg;
    logic [31:0] of_val;
    logic [3:0]  wr_rd;
    logic [31:0] wr_val;
    logic [31:0] x_pc;
    logic [5:0]  x_op;
    logic [3:0]  x_rd;
    logic [31:0] x_rs, x_rt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_operand(input logic [3:0] idx);
    if (idx == 0) return 32'h0;
    if (idx == exec_of_reg) return exec_of_val;
    if (idx == exec_rd) return exec_rd_val;
    return m_regs[idx];
  endfunction

  // One clock: check rr_stall, advance the model, step, compare the bundle.
  task automatic tick();
    logic [31:0] nrs, nrt;
    #1;
    chk("rr_stall", {31'b0, rr_stall}, {31'b0, exec_stall});
    nrs = m_operand(dec_rs);
    nrt = m_operand(dec_rt);
    if (!i_reset_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    end else if (exec_rd != 0) begin
      m_regs[exec_rd] = exec_rd_val;
    end
    if (!i_reset_n || (!exec_stall && (exec_flush || !dec_valid))) begin
      {e_pc, e_imm, e_pcinc, e_rs, e_rt} = '0;
      e_op = '0; e_altop = '0; e_rd = '0; e_nic = 1'b0;
    end else if (!exec_stall) begin
      e_pc = dec_pc; e_imm = dec_imm32; e_pcinc = dec_pc_inc;
      e_rs = nrs; e_rt = nrt;
      e_op = dec_op; e_altop = dec_altop; e_rd = dec_rd; e_nic = dec_next_is_cont;
    end
    @(posedge i_clk);
    #1;
    chk("rr_pc", rr_pc, e_pc);
    chk("rr_imm32", rr_imm32, e_imm);
    chk("rr_pc_inc", rr_pc_inc, e_pcinc);
    chk("rr_rs_val", rr_rs_val, e_rs);
    chk("rr_rt_val", rr_rt_val, e_rt);
    chk("rr_op", {26'b0, rr_op}, {26'b0, e_op});
    chk("rr_altop", {24'b0, rr_altop}, {24'b0, e_altop});
    chk("rr_rd", {28'b0, rr_rd}, {28'b0, e_rd});
    chk("rr_nic", {31'b0, rr_next_is_cont}, {31'b0, e_nic});
  endtask

  task automatic idle();
    dec_valid = 0; dec_pc = 0; dec_imm32 = 0; dec_pc_inc = 0; dec_op = 0;
    dec_altop = 0; dec_rd = 0; dec_rs = 0; dec_rt = 0; dec_next_is_cont = 0;
    exec_stall = 0; exec_flush = 0; exec_of_reg = 0; exec_of_val = 0;
    exec_rd = 0; exec_rd_val = 0;
  endtask

  initial begin
    //        stl flu val pc      op     rd    rs    rt    ofr   ofv       wrd   wval          x_pc    x_op   x_rd  x_rs          x_rt
    tbl[0]  = '{0, 0, 0, 32'h00, 6'h00, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0,    4'h5, 32'h1234,     32'h00, 6'h00, 4'h0, 32'h0,        32'h0};
    tbl[1]  = '{0, 0, 1, 32'h10, 6'h01, 4'h2, 4'h5, 4'h0, 4'h0, 32'h0,    4'h0, 32'h0,        32'h10, 6'h01, 4'h2, 32'h1234,     32'h0};
    tbl[2]  = '{0, 0, 1, 32'h14, 6'h02, 4'h3, 4'h5, 4'h0, 4'h5, 32'hDEAD, 4'h0, 32'h0,        32'h14, 6'h02, 4'h3, 32'hDEAD,     32'h0};
    tbl[3]  = '{0, 0, 1, 32'h18, 6'h03, 4'h4, 4'h7, 4'h7, 4'h7, 32'hA,    4'h7, 32'hB,        32'h18, 6'h03, 4'h4, 32'hA,        32'hA};
    tbl[4]  = '{0, 0, 1, 32'h1C, 6'h04, 4'h6, 4'h7, 4'h0, 4'h0, 32'h0,    4'h0, 32'h0,        32'h1C, 6'h04, 4'h6, 32'hB,        32'h0};
    tbl[5]  = '{0, 0, 1, 32'h20, 6'h05, 4'h1, 4'h0, 4'h0, 4'h0, 32'h55,   4'h0, 32'hFFFFFFFF, 32'h20, 6'h05, 4'h1, 32'h0,        32'h0};
    tbl[6]  = '{0, 0, 1, 32'h24, 6'h06, 4'h8, 4'h9, 4'h0, 4'h3, 32'h0,    4'h9, 32'h77,       32'h24, 6'h06, 4'h8, 32'h77,       32'h0};
    tbl[7]  = '{0, 0, 0, 32'h99, 6'h3F, 4'hA, 4'h9, 4'h9, 4'h0, 32'h0,    4'h0, 32'h0,        32'h00, 6'h00, 4'h0, 32'h0,        32'h0};
    tbl[8]  = '{0, 0, 1, 32'h28, 6'h07, 4'h9, 4'h9, 4'h5, 4'h0, 32'h0,    4'h0, 32'h0,        32'h28, 6'h07, 4'h9, 32'h77,       32'h1234};
    tbl[9]  = '{0, 0, 1, 32'h40, 6'h09, 4'hC, 4'h0, 4'h0, 4'h0, 32'h0,    4'h0, 32'h0,        32'h40, 6'h09, 4'hC, 32'h0,        32'h0};
    tbl[10] = '{1, 1, 1, 32'h80, 6'h11, 4'hF, 4'h5, 4'h5, 4'h0, 32'h0,    4'h0, 32'h0,        32'h40, 6'h09, 4'hC, 32'h0,        32'h0};
    tbl[11] = '{1, 1, 1, 32'h80, 6'h11, 4'hF, 4'h5, 4'h5, 4'h0, 32'h0,    4'h0, 32'h0,        32'h40, 6'h09, 4'hC, 32'h0,        32'h0};
    tbl[12] = '{1, 1, 1, 32'h80, 6'h11, 4'hF, 4'h5, 4'h5, 4'h0, 32'h0,    4'h0, 32'h0,        32'h40, 6'h09, 4'hC, 32'h0,        32'h0};
    tbl[13] = '{0, 1, 1, 32'h80, 6'h11, 4'hF, 4'h5, 4'h5, 4'h0, 32'h0,    4'h0, 32'h0,        32'h00, 6'h00, 4'h0, 32'h0,        32'h0};
    tbl[14] = '{0, 0, 1, 32'h44, 6'h0A, 4'h5, 4'h5, 4'h0, 4'h0, 32'h0,    4'h0, 32'h0,        32'h44, 6'h0A, 4'h5, 32'h1234,     32'h0};

    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    {e_pc, e_imm, e_pcinc, e_rs, e_rt} = '0;
    e_op = '0; e_altop = '0; e_rd = '0; e_nic = 1'b0;
    idle();

    // Reset held with a live instruction and a pending write to r3.
    i_reset_n = 0; dec_valid = 1; dec_op = 6'h08; dec_pc = 32'h100; dec_rd = 4'h3;
    exec_rd = 4'h3; exec_rd_val = 32'hCAFE;
    tick();
    tick();
    chk("reset_rr_op", {26'b0, rr_op}, 32'h0);
    idle();
    i_reset_n = 1; dec_valid = 1; dec_rs = 4'h3; dec_rt = 4'h3; dec_pc = 32'h4;
    tick();
    chk("reset_r3_read", rr_rs_val, 32'h0);

    foreach (tbl[i]) begin
      exec_stall = tbl[i].stall; exec_flush = tbl[i].flush; dec_valid = tbl[i].valid;
      dec_pc = tbl[i].pc; dec_op = tbl[i].op; dec_rd = tbl[i].rd;
      dec_rs = tbl[i].rs; dec_rt = tbl[i].rt;
      dec_imm32 = {tbl[i].pc[15:0], 16'h0}; dec_pc_inc = tbl[i].pc + 32'd4;
      dec_altop = {2'b0, tbl[i].op} + 8'd1; dec_next_is_cont = tbl[i].pc[2];
      exec_of_reg = tbl[i].of_reg; exec_of_val = tbl[i].of_val;
      exec_rd = tbl[i].wr_rd; exec_rd_val = tbl[i].wr_val;
      tick();
      chk($sformatf("tbl%0d_pc", i), rr_pc, tbl[i].x_pc);
      chk($sformatf("tbl%0d_op", i), {26'b0, rr_op}, {26'b0, tbl[i].x_op});
      chk($sformatf("tbl%0d_rd", i), {28'b0, rr_rd}, {28'b0, tbl[i].x_rd});
      chk($sformatf("tbl%0d_rs", i), rr_rs_val, tbl[i].x_rs);
      chk($sformatf("tbl%0d_rt", i), rr_rt_val, tbl[i].x_rt);
    end

    // Reset arriving in the middle of a stall.
    idle();
    dec_valid = 1; dec_pc = 32'h123; dec_op = 6'h2;
    tick();
    exec_stall = 1; dec_pc = 32'h200; exec_rd = 4'h5; exec_rd_val = 32'h5555;
    tick();
    chk("stall_hold_pc", rr_pc, 32'h123);
    i_reset_n = 0;
    tick();
    chk("reset_in_stall_pc", rr_pc, 32'h0);
    idle();
    i_reset_n = 1; dec_valid = 1; dec_rs = 4'h5; dec_pc = 32'h300;
    tick();
    chk("reset_in_stall_r5", rr_rs_val, 32'h0);

    // Random traffic with occasional reset; small index range for frequent hazards.
    for (int n = 0; n < 400; n++) begin
      i_reset_n = ($urandom_range(0, 49) != 0);
      exec_stall = ($urandom_range(0, 3) == 0);
      exec_flush = ($urandom_range(0, 7) == 0);
      dec_valid = ($urandom_range(0, 3) != 0);
      dec_pc = $urandom; dec_imm32 = $urandom; dec_pc_inc = $urandom;
      dec_op = 6'($urandom); dec_altop = 8'($urandom);
      dec_rd = 4'($urandom); dec_next_is_cont = 1'($urandom);
      dec_rs = 4'($urandom_range(0, 5)); dec_rt = 4'($urandom_range(0, 5));
      exec_of_reg = 4'($urandom_range(0, 5)); exec_of_val = $urandom;
      exec_rd = 4'($urandom_range(0, 5)); exec_rd_val = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Register-read stage of the cs3220 core pipeline, sitting between decode and `execute_stage`. Holds the 16×32 architectural register file, reads the rs/rt operands of the decoded instruction, and resolves RAW hazards by forwarding from execute. Registers the full `rr_*` bundle that execute consumes. Honours execute's stall and flush, and performs register writeback from execute's registered result.

## Interface
Parameters:
- NREGS, 16, register count; register index width is 4.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset_n  in  1  reset; synchronous, active-low
- dec_valid  in  1  decode presents a real instruction; 0 means bubble
- dec_pc, dec_imm32, dec_pc_inc  in  32 each  decoded PC, sign-extended immediate, sequential next PC
- dec_op  in  6  primary opcode
- dec_altop  in  8  extended opcode
- dec_rd, dec_rs, dec_rt  in  4 each  destination and source register indices
- dec_next_is_cont  in  1  decode's fall-through prediction flag, passed through
- exec_stall, exec_flush  in  1 each  stall and flush requests from execute
- exec_of_reg  in  4  forwarding register index (the instruction currently in execute)
- exec_of_val  in  32  forwarding value
- exec_rd  in  4  writeback register index
- exec_rd_val  in  32  writeback value
- rr_pc, rr_imm32, rr_pc_inc, rr_rs_val, rr_rt_val  out  32 each  registered to execute
- rr_op  out  6  registered opcode to execute
- rr_altop  out  8  registered extended opcode to execute
- rr_rd  out  4  registered destination index to execute
- rr_next_is_cont  out  1  registered fall-through flag to execute
- rr_stall  out  1  to decode: hold the current instruction

## Operation
- **Register file.** 16 flops of 32 bits.
  - r0 is hardwired zero: reads return 0 and writes to index 0 are discarded.
  - Index 0 in rd is the no-write encoding, so bubbles need no valid bit.
- **Writeback.** Every cycle with exec_rd != 0, store exec_rd_val into regs[exec_rd]. This happens regardless of stall. Execute holds exec_rd stable while it stalls, so rewriting the same value is benign.
- **Operand select.** Applied independently for rs and rt, highest priority first:
  1. index == 0 → 0.
  2. index == exec_of_reg → exec_of_val. This forwards from the instruction in execute.
  3. index == exec_rd → exec_rd_val. This is the writeback bypass for the same-cycle write.
  4. Otherwise regs[index].
- **Pipeline register update.** Priority per cycle:
  1. **Hold:** exec_stall=1 → all rr_* keep their values. The stall beats flush.
  2. **Flush:** exec_flush=1 → load a bubble: rr_op=0, rr_altop=0, rr_rd=0, rr_rs_val=0, rr_rt_val=0, rr_next_is_cont=0. rr_pc, rr_pc_inc and rr_imm32 are also zeroed. Decode's current instruction is dropped.
  3. **Load:** dec_valid=1 → capture the decode fields and the selected operands.
  4. **Bubble:** dec_valid=0 → load a bubble as in the flush case.
- **Upstream stall.** rr_stall = exec_stall, combinational. Decode must hold its outputs while rr_stall=1.
- **Inferred halt.** A sustained exec_stall holds the stage indefinitely. Writeback continues to be applied with the same value each cycle.

## Timing
- Latency: decode fields → rr_* in 1 cycle.
- Regfile write → visible to a read:
  - In the same cycle through the exec_rd bypass.
  - From the register itself on the next cycle.
- Reset (i_reset_n=0 at an edge):
  - All rr_* outputs are 0, which is a bubble.
  - All 16 registers are 0.
  - rr_stall follows exec_stall.
  - Reset beats stall, flush and writeback.
- First instruction can load on the first edge with i_reset_n=1.
- **Back-to-back dependence.** If the instruction in rr writes rX and decode's instruction reads rX, the operand comes from exec_of_val with no bubble.
- **Distance-2 dependence.** Served from exec_rd_val.
- **Simultaneous stall and flush.** Hold. Flush is re-evaluated once the stall clears.
- **Reset mid-stall.** Reset beats the stall: outputs go to bubble and registers clear.
- exec_of_reg is combinational from rr_rd. The whole operand select is combinational. The loop closes only through the flops, with no combinational path through rr_*.

## Test plan
- **Reset.** Hold i_reset_n=0 for 2 cycles with dec_valid=1, dec_op=ADDI, exec_rd=3 → all rr_* are 0 and reading r3 afterwards returns 0.
- **Forwarding.** Drive exec_rd=5, exec_rd_val=0x1234 for 1 cycle, then idle. Then decode an instruction with rs=5 and rt=0 while exec_of_reg=0 → rr_rs_val=0x1234, rr_rt_val=0. Then decode rs=5 while exec_of_reg=5, exec_of_val=0xDEAD → rr_rs_val=0xDEAD.
- **Bypass priority.** Set exec_of_reg=7 with exec_of_val=0xA, and exec_rd=7 with exec_rd_val=0xB. Decode rs=7 → rr_rs_val=0xA. In the same cycle regs[7] becomes 0xB.
- **r0.** Drive exec_rd=0 with exec_rd_val=0xFFFF_FFFF, and exec_of_reg=0 with exec_of_val=0x55. Decode rs=0 → rr_rs_val=0.
- **Stall/flush.** With rr holding pc=0x40, assert exec_stall=1 and exec_flush=1 for 3 cycles → rr_pc stays 0x40 and rr_stall=1. Then drop exec_stall with exec_flush=1 → next cycle rr_op=0, rr_rd=0 and the decode instruction is discarded.
- **Bubble.** dec_valid=0 for 1 cycle → rr_op=0, rr_altop=0, rr_rd=0. The following dec_valid=1 instruction loads normally.
